// File: rtl/regfile_wb_sequencer_pkg.sv
// Shared types for the register-file writeback sequencer: FSM states,
// requester identities and the hard-wired zero register index.
package regfile_wb_sequencer_pkg;

  typedef enum logic {INIT, RUN} state_t;

  // Encoding doubles as the bit position in the arbiter request/grant vectors.
  typedef enum logic {SRC_ALU, SRC_MEM} src_t;

  localparam int X0 = 0;

endpackage

// File: rtl/regfile_wb_sequencer_if.sv
// Writeback bus: two requester channels (ALU, load unit) plus the
// register-file write port driven by the sequencer.
interface regfile_wb_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // Valid/ready: a transfer happens on a cycle where valid && ready are both
  // high; while valid is high and ready is low, rd/data must stay unchanged.
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic [ADDR_W-1:0] rd;
  logic              writeEnable;
  logic [DATA_W-1:0] writeData;

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, rd, writeEnable, writeData
  );

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, rd, writeEnable, writeData
  );
endinterface

// File: rtl/regfile_wb_sequencer_arb.sv
// Two-input round-robin arbiter; pri names the source that wins a tie.
// x0 requests are expected to be masked off before they reach req.
module wb_rr_arbiter2
  import regfile_wb_sequencer_pkg::*;
(
  input  logic [1:0] req,
  input  src_t       pri,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (pri == SRC_MEM) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wb_sequencer.sv
// Single write-port owner for the integer register file: clears x1..x31
// after reset, then arbitrates ALU and load writebacks round-robin.
module regfile_wb_sequencer
  import regfile_wb_sequencer_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_REGS   = 32,
  parameter int INIT_CLEAR = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_wb_sequencer_if.slave  wb,
  output logic                   init_done,
  output state_t                 state
);

  state_t            stateNext;
  logic [ADDR_W-1:0] cnt;
  src_t              rrPri;
  logic              initDoneQ;
  logic              running;
  logic              lastClear;
  logic              aluNz;
  logic              memNz;
  logic [1:0]        req;
  logic [1:0]        gnt;

  assign running   = !rst && (state == RUN);
  assign lastClear = (cnt == ADDR_W'(NUM_REGS - 1));
  assign aluNz     = wb.alu_valid && (wb.alu_rd != ADDR_W'(X0));
  assign memNz     = wb.mem_valid && (wb.mem_rd != ADDR_W'(X0));
  assign req       = running ? {memNz, aluNz} : 2'b00;

  wb_rr_arbiter2 u_arb (
    .req (req),
    .pri (rrPri),
    .gnt (gnt)
  );

  // x0 writes are acknowledged and dropped without consuming arbitration.
  assign wb.alu_ready = running && wb.alu_valid &&
                        ((wb.alu_rd == ADDR_W'(X0)) || gnt[SRC_ALU]);
  assign wb.mem_ready = running && wb.mem_valid &&
                        ((wb.mem_rd == ADDR_W'(X0)) || gnt[SRC_MEM]);

  // With no clear sequence, readiness is visible as soon as reset drops.
  assign init_done = initDoneQ || ((INIT_CLEAR == 0) && !rst);

  always_comb begin
    stateNext = state;
    if (state == INIT && lastClear) stateNext = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= (INIT_CLEAR != 0) ? INIT : RUN;
    else     state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= ADDR_W'(1);
      rrPri          <= SRC_MEM;
      initDoneQ      <= 1'b0;
      wb.rd          <= '0;
      wb.writeEnable <= 1'b0;
      wb.writeData   <= '0;
    end else if (state == INIT) begin
      wb.rd          <= cnt;
      wb.writeData   <= '0;
      wb.writeEnable <= 1'b1;
      cnt            <= cnt + ADDR_W'(1);
      if (lastClear) initDoneQ <= 1'b1;
    end else if (gnt[SRC_ALU]) begin
      wb.rd          <= wb.alu_rd;
      wb.writeData   <= wb.alu_data;
      wb.writeEnable <= 1'b1;
      rrPri          <= SRC_MEM;
    end else if (gnt[SRC_MEM]) begin
      wb.rd          <= wb.mem_rd;
      wb.writeData   <= wb.mem_data;
      wb.writeEnable <= 1'b1;
      rrPri          <= SRC_ALU;
    end else begin
      wb.writeEnable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Bench for regfile_wb_sequencer: clear sequence, directed arbitration table,
// mid-clear reset, randomized traffic against a reference model, INIT_CLEAR=0.
module tb_regfile_wb_sequencer;
  import regfile_wb_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst0 = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_sequencer_if bus ();
  regfile_wb_sequencer_if bus0 ();
  logic   initDone, initDone0;
  state_t st, st0;

  regfile_wb_sequencer #(.INIT_CLEAR(1)) u_dut (
    .clk(clk), .rst(rst), .wb(bus), .init_done(initDone), .state(st)
  );
  regfile_wb_sequencer #(.INIT_CLEAR(0)) u_dut0 (
    .clk(clk), .rst(rst0), .wb(bus0), .init_done(initDone0), .state(st0)
  );

  int nPass = 0;
  int nTotal = 0;

  logic [37:0] exp_q[$];  // {writeEnable, rd, writeData}

  logic        aV, mV;
  logic [4:0]  aRd, mRd;
  logic [31:0] aD, mD;

  typedef struct {
    logic aV; logic [4:0] aRd; logic [31:0] aD;
    logic mV; logic [4:0] mRd; logic [31:0] mD;
    logic expAR; logic expMR;
    logic expWe; logic [4:0] expRd; logic [31:0] expWd;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic apply();
    bus.alu_valid = aV; bus.alu_rd = aRd; bus.alu_data = aD;
    bus.mem_valid = mV; bus.mem_rd = mRd; bus.mem_data = mD;
  endtask

  task automatic set_req(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    aV = av; aRd = ard; aD = ad; mV = mv; mRd = mrd; mD = md;
    apply();
  endtask

  function automatic logic [4:0] rand_rd();
    if ($urandom_range(0, 3) == 0) return 5'd0;
    return 5'($urandom_range(1, 31));
  endfunction

  // Expects the cycle right after a reset edge; checks the 31 clear writes.
  task automatic init_seq();
    for (int i = 1; i <= 31; i++) begin
      @(posedge clk); #1;
      chk("init_we", 32'(bus.writeEnable), 32'd1);
      chk("init_rd", 32'(bus.rd), 32'(i));
      chk("init_wd", bus.writeData, 32'd0);
      chk("init_done", 32'(initDone), (i == 31) ? 32'd1 : 32'd0);
      if (i < 31) begin
        chk("init_alu_ready", 32'(bus.alu_ready), 32'd0);
        chk("init_mem_ready", 32'(bus.mem_ready), 32'd0);
      end else begin
        chk("init_state_run", 32'(st), 32'(RUN));
        set_req(0, 0, 0, 0, 0, 0);
      end
    end
  endtask

  initial begin
    logic [37:0] e;
    src_t        prio;
    logic [4:0]  lastRd;
    logic [31:0] lastWd;
    logic        aNz, mNz, gA, gM, eAR, eMR;

    // rr_pri starts at MEM after the clear; hand-derived table.
    vecs[0] = '{1, 5,  32'hDEADBEEF, 0, 0,  0,        1, 0, 1, 5,  32'hDEADBEEF};
    vecs[1] = '{1, 3,  32'h11,       1, 4,  32'h22,   0, 1, 1, 4,  32'h22};
    vecs[2] = '{1, 3,  32'h11,       1, 6,  32'h33,   1, 0, 1, 3,  32'h11};
    vecs[3] = '{1, 8,  32'h44,       1, 6,  32'h33,   0, 1, 1, 6,  32'h33};
    vecs[4] = '{1, 8,  32'h44,       1, 9,  32'h55,   1, 0, 1, 8,  32'h44};
    vecs[5] = '{1, 0,  32'h99,       1, 7,  32'h77,   1, 1, 1, 7,  32'h77};
    vecs[6] = '{1, 0,  32'h98,       1, 0,  32'h97,   1, 1, 0, 7,  32'h77};
    vecs[7] = '{0, 0,  0,            0, 0,  0,        0, 0, 0, 7,  32'h77};
    vecs[8] = '{1, 10, 32'hA,        1, 10, 32'hB,    1, 0, 1, 10, 32'hA};
    vecs[9] = '{1, 10, 32'hC,        1, 10, 32'hB,    0, 1, 1, 10, 32'hB};

    bus0.alu_valid = 1; bus0.alu_rd = 2; bus0.alu_data = 32'h1234;
    bus0.mem_valid = 0; bus0.mem_rd = 0; bus0.mem_data = 0;

    // Reset and clear sequence with both requesters pushing throughout.
    set_req(1, 3, 32'h1, 1, 4, 32'h2);
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_we", 32'(bus.writeEnable), 32'd0);
    chk("rst_rd", 32'(bus.rd), 32'd0);
    chk("rst_wd", bus.writeData, 32'd0);
    chk("rst_init_done", 32'(initDone), 32'd0);
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    chk("rst_state", 32'(st), 32'(INIT));
    rst = 0; #1;
    chk("init0_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("init0_mem_ready", 32'(bus.mem_ready), 32'd0);
    init_seq();

    // Directed arbitration table; the write appears one cycle after the row.
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        chk("idle_we", 32'(bus.writeEnable), 32'd0);
        chk("idle_rd_hold", 32'(bus.rd), 32'd31);
        chk("idle_wd_hold", bus.writeData, 32'd0);
      end else begin
        chk($sformatf("vec%0d_we", k - 1), 32'(bus.writeEnable), 32'(vecs[k-1].expWe));
        chk($sformatf("vec%0d_rd", k - 1), 32'(bus.rd), 32'(vecs[k-1].expRd));
        chk($sformatf("vec%0d_wd", k - 1), bus.writeData, vecs[k-1].expWd);
      end
      if (k < 10) begin
        set_req(vecs[k].aV, vecs[k].aRd, vecs[k].aD, vecs[k].mV, vecs[k].mRd, vecs[k].mD);
        #1;
        chk($sformatf("vec%0d_alu_ready", k), 32'(bus.alu_ready), 32'(vecs[k].expAR));
        chk($sformatf("vec%0d_mem_ready", k), 32'(bus.mem_ready), 32'(vecs[k].expMR));
      end else begin
        set_req(0, 0, 0, 0, 0, 0);
      end
    end

    // Reset pulse in the middle of the clear sequence.
    set_req(1, 12, 32'h5, 1, 13, 32'h6);
    rst = 1;
    @(posedge clk); #1;
    chk("rst2_we", 32'(bus.writeEnable), 32'd0);
    rst = 0;
    for (int i = 1; i <= 10; i++) @(posedge clk);
    #1;
    chk("mid_rd10", 32'(bus.rd), 32'd10);
    chk("mid_we", 32'(bus.writeEnable), 32'd1);
    rst = 1;
    @(posedge clk); #1;
    chk("mid_rst_we", 32'(bus.writeEnable), 32'd0);
    chk("mid_rst_init_done", 32'(initDone), 32'd0);
    chk("mid_rst_state", 32'(st), 32'(INIT));
    rst = 0;
    init_seq();

    // Randomized traffic; requesters hold until acknowledged.
    prio = SRC_MEM; lastRd = 5'd31; lastWd = 32'd0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rand_we", 32'(bus.writeEnable), 32'(e[37]));
        chk("rand_rd", 32'(bus.rd), 32'(e[36:32]));
        chk("rand_wd", bus.writeData, e[31:0]);
      end
      if (!aV && $urandom_range(0, 3) != 0) begin aV = 1; aRd = rand_rd(); aD = $urandom; end
      if (!mV && $urandom_range(0, 3) != 0) begin mV = 1; mRd = rand_rd(); mD = $urandom; end
      apply(); #1;
      aNz = aV && (aRd != 0);
      mNz = mV && (mRd != 0);
      gA  = aNz && (!mNz || prio == SRC_ALU);
      gM  = mNz && !gA;
      eAR = (aV && aRd == 0) || gA;
      eMR = (mV && mRd == 0) || gM;
      chk("rand_alu_ready", 32'(bus.alu_ready), 32'(eAR));
      chk("rand_mem_ready", 32'(bus.mem_ready), 32'(eMR));
      if (gA) begin
        lastRd = aRd; lastWd = aD; prio = SRC_MEM;
        exp_q.push_back({1'b1, aRd, aD});
      end else if (gM) begin
        lastRd = mRd; lastWd = mD; prio = SRC_ALU;
        exp_q.push_back({1'b1, mRd, mD});
      end else begin
        exp_q.push_back({1'b0, lastRd, lastWd});
      end
      if (eAR) aV = 0;
      if (eMR) mV = 0;
    end
    @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rand_last_we", 32'(bus.writeEnable), 32'(e[37]));
      chk("rand_last_rd", 32'(bus.rd), 32'(e[36:32]));
      chk("rand_last_wd", bus.writeData, e[31:0]);
    end
    set_req(0, 0, 0, 0, 0, 0);

    // INIT_CLEAR=0 instance: held in reset until now.
    chk("nc_rst_init_done", 32'(initDone0), 32'd0);
    chk("nc_rst_ready", 32'(bus0.alu_ready), 32'd0);
    chk("nc_rst_we", 32'(bus0.writeEnable), 32'd0);
    rst0 = 0; #1;
    chk("nc_init_done", 32'(initDone0), 32'd1);
    chk("nc_alu_ready", 32'(bus0.alu_ready), 32'd1);
    chk("nc_no_clear_we", 32'(bus0.writeEnable), 32'd0);
    chk("nc_state", 32'(st0), 32'(RUN));
    @(posedge clk); #1;
    bus0.alu_valid = 0;
    chk("nc_wr_we", 32'(bus0.writeEnable), 32'd1);
    chk("nc_wr_rd", 32'(bus0.rd), 32'd2);
    chk("nc_wr_wd", bus0.writeData, 32'h1234);
    @(posedge clk); #1;
    chk("nc_idle_we", 32'(bus0.writeEnable), 32'd0);
    chk("nc_init_done_hold", 32'(initDone0), 32'd1);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sequencer.md
Name: regfile_wb_sequencer

Overview:
- Owns the single write port of the 32x32 integer register file.
- After reset, it sequences a clear of x1..x31, because the register file has no reset clear of its own.
- Afterwards it arbitrates two writeback requesters, ALU and load unit, onto the one port using valid/ready handshakes and round-robin fairness.
- It sits between the execute/memory stages and the register file's rd / writeEnable / writeData inputs.

Parameters:
- DATA_W, 32, writeback data width.
- ADDR_W, 5, register index width.
- NUM_REGS, 32, number of architectural registers. Must equal 2**ADDR_W.
- INIT_CLEAR, 1, clear control. 1: run the clear sequence after reset. 0: go straight to RUN.

Ports:
- clk  in  1  core clock, rising-edge.
- rst  in  1  synchronous reset, active-high.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- mem_valid  in  1  load writeback request.
- mem_rd  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- mem_ready  out  1  load request accepted this cycle.
- rd  out  ADDR_W  register-file write address.
- writeEnable  out  1  register-file write strobe.
- writeData  out  DATA_W  register-file write data.
- init_done  out  1  high once the clear sequence has finished, then stays high.

Behaviour:
- One clock domain, clk. Reset rst is synchronous and active-high.
- rst high at a clock edge:
  - state <= INIT if INIT_CLEAR=1, else RUN.
  - clear counter <= 1.
  - rr_pri <= MEM.
  - rd, writeEnable, writeData, init_done <= 0.
- alu_ready and mem_ready are combinational. Both are 0 while rst is high or state is INIT.
- States:
  - INIT: each cycle, register rd=cnt, writeData=0, writeEnable=1, then cnt++. After the cycle issuing cnt=NUM_REGS-1, go to RUN; init_done <= 1 on that same edge. Duration is 31 cycles. Requester valids are ignored; requesters must hold their requests until ready.
  - RUN: arbitration, described below.
- Acceptance: a transfer occurs when valid && ready in the same cycle. Requesters hold rd and data stable while valid is high and ready is low.
- x0 requests: valid with rd==0 gets ready=1 in RUN immediately, independent of arbitration. The request is discarded, writeEnable stays 0, and rr_pri is unchanged. Both sources may be acked in one cycle this way.
- Non-x0 requests:
  - Only one source is granted per cycle.
  - If only one source is valid, it is granted.
  - If both are valid, the source equal to rr_pri wins.
  - After a grant, rr_pri <= the other source.
- Write-port outputs are registered. A request accepted in cycle N drives rd, writeEnable=1 and writeData in cycle N+1, so the register file captures it at the end of N+1. With no grant, writeEnable <= 0 and rd/writeData hold their previous values.
- Same rd from both sources in consecutive grants: the writes are issued in grant order, and the later grant's data ends up in the register file.
- Throughput: one non-x0 write per cycle, sustained. The loser of a conflict waits at least 1 cycle.
- rst asserted mid-INIT or mid-RUN: the clear restarts from cnt=1. A write registered in the prior cycle is dropped, because writeEnable is cleared at the reset edge.

Decomposition:
- Shared package holds:
  - state enum {INIT, RUN};
  - source enum {SRC_ALU, SRC_MEM};
  - localparam X0 = 0.
- Natural sub-module: wb_rr_arbiter2. It is a two-input round-robin arbiter taking req[1:0] plus its pri flop and producing a one-hot gnt. It excludes x0 requests, which are masked before it.

Test Plan:
- Reset with INIT_CLEAR=1 -> writeEnable=1 for exactly 31 cycles with rd=1..31 and writeData=0. init_done rises with the last write. ready stays 0 throughout, even with both valids held high.
- RUN, alu_valid only, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1 in cycle N; cycle N+1 has rd=5, writeEnable=1, writeData=0xDEADBEEF.
- Both valid for 4 cycles with non-x0 rd -> grants MEM, ALU, MEM, ALU (rr_pri reset=MEM). writeEnable high on each of the 4 following cycles.
- Both valid, alu_rd=0, mem_rd=7 -> both ready=1 in the same cycle. Only the rd=7 write is issued; rr_pri flips to ALU.
- rst pulsed for 1 cycle at clear count 10 -> writeEnable=0 on the next cycle, then the clear sequence reruns from rd=1 with init_done=0 until it completes.
- INIT_CLEAR=0 -> init_done=1 and ready available in the first cycle after rst falls, with no clear writes.
